// File: rtl/muldiv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_ctrl_pkg
// Description : Shared definitions for the HI/LO multiply/divide sequencer.
//               Holds the R-form function codes, the FSM state encoding,
//               the datapath step mode and the iteration count.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_ctrl_pkg;

    // R-form function codes handled by the HI/LO unit
    localparam logic [5:0] FUNC_MFHI  = 6'h10;
    localparam logic [5:0] FUNC_MTHI  = 6'h11;
    localparam logic [5:0] FUNC_MFLO  = 6'h12;
    localparam logic [5:0] FUNC_MTLO  = 6'h13;
    localparam logic [5:0] FUNC_MULT  = 6'h18;
    localparam logic [5:0] FUNC_MULTU = 6'h19;
    localparam logic [5:0] FUNC_DIV   = 6'h1A;
    localparam logic [5:0] FUNC_DIVU  = 6'h1B;

    localparam int MULDIV_ITERS = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_e;

    typedef enum logic {
        STEP_MUL = 1'b0,
        STEP_DIV = 1'b1
    } step_mode_e;

    // True for every function code that touches HI/LO and must therefore
    // wait while an operation is in flight.
    function automatic logic is_hilo_func(input logic [5:0] f);
        return (f == FUNC_MFHI) || (f == FUNC_MTHI) ||
               (f == FUNC_MFLO) || (f == FUNC_MTLO) ||
               (f == FUNC_MULT) || (f == FUNC_MULTU) ||
               (f == FUNC_DIV)  || (f == FUNC_DIVU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_step
// Description : One purely combinational iteration of the unsigned
//               shift-add multiplier or the restoring divider.
//   i_mode    : STEP_MUL or STEP_DIV
//   i_acc     : 2*WIDTH accumulator. MUL: {partial product, multiplier};
//               DIV: {partial remainder, dividend/quotient bits}
//   i_operand : multiplicand (MUL) or divisor (DIV), both as magnitudes
//   o_acc     : accumulator after this iteration (quotient bit in LSB for DIV)
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_step
    import muldiv_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  step_mode_e         i_mode,
    input  logic [2*WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0]   i_operand,
    output logic [2*WIDTH-1:0] o_acc
);

    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH-1:0] w_diff;
    logic             w_qbit;

    always_comb begin
        // Multiply: conditionally add the multiplicand into the upper half,
        // keeping the carry, then shift the whole accumulator right.
        w_add    = {1'b0, i_acc[2*WIDTH-1:WIDTH]}
                 + (i_acc[0] ? {1'b0, i_operand} : {(WIDTH+1){1'b0}});
        // Divide: shift the next dividend bit into the remainder. The shifted
        // remainder is below 2*divisor, so a successful subtraction always
        // fits back into WIDTH bits and modular subtraction is exact.
        w_rem_sh = i_acc[2*WIDTH-1:WIDTH-1];
        w_qbit   = (w_rem_sh >= {1'b0, i_operand});
        w_diff   = w_rem_sh[WIDTH-1:0] - i_operand;

        if (i_mode == STEP_MUL) begin
            o_acc = {w_add, i_acc[WIDTH-1:1]};
        end else begin
            o_acc = {(w_qbit ? w_diff : w_rem_sh[WIDTH-1:0]),
                     i_acc[WIDTH-2:0], w_qbit};
        end
    end

endmodule
`default_nettype wire

// File: rtl/muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_ctrl
// Description : Multi-cycle sequencer for the HI/LO multiply/divide unit.
//               Runs MULT/MULTU/DIV/DIVU in a fixed 34-cycle cadence,
//               executes MTHI/MTLO and stalls HI/LO users while busy.
//   CLK, RST  : clock, synchronous active-low reset
//   Valid     : decoded R-form instruction present
//   Func      : R-form function code
//   Rdata1/2  : rs (dividend) / rt (divisor) operands
//   Busy      : operation in flight
//   Stall     : hold the current HI/LO instruction (combinational)
//   Done      : one-cycle pulse, HI/LO hold a new result
//   HI, LO    : HI/LO registers
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Valid,
    input  logic [5:0]       Func,
    input  logic [WIDTH-1:0] Rdata1,
    input  logic [WIDTH-1:0] Rdata2,
    output logic             Busy,
    output logic             Stall,
    output logic             Done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int            CW     = $clog2(MULDIV_ITERS);
    localparam logic [CW-1:0] c_LAST = CW'(MULDIV_ITERS - 1);

    state_e             r_state, w_next_state;
    logic [CW-1:0]      r_count;
    logic [2*WIDTH-1:0] r_acc, w_acc_step, w_prod;
    logic [WIDTH-1:0]   r_operand, r_rs_raw, r_hi, r_lo;
    logic [WIDTH-1:0]   w_rs_mag, w_rt_mag, w_fix_hi, w_fix_lo;
    logic               r_is_div, r_neg_res, r_neg_rem, r_div_zero, r_done;
    logic               w_is_op, w_is_div, w_signed, w_rs_neg, w_rt_neg;
    logic               w_accept, w_busy;

    // ---------------- operand decode ----------------
    always_comb begin
        w_is_div = (Func == FUNC_DIV) || (Func == FUNC_DIVU);
        w_is_op  = w_is_div || (Func == FUNC_MULT) || (Func == FUNC_MULTU);
        w_signed = (Func == FUNC_MULT) || (Func == FUNC_DIV);
        w_rs_neg = w_signed & Rdata1[WIDTH-1];
        w_rt_neg = w_signed & Rdata2[WIDTH-1];
        // Negating the most negative value yields the same bit pattern,
        // which read as unsigned is exactly its magnitude 2^(WIDTH-1).
        w_rs_mag = w_rs_neg ? -Rdata1 : Rdata1;
        w_rt_mag = w_rt_neg ? -Rdata2 : Rdata2;
    end

    // ---------------- FSM ----------------
    always_ff @(posedge CLK) begin
        if (!RST) r_state <= ST_IDLE;
        else      r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_busy       = (r_state != ST_IDLE);
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_accept = Valid && w_is_op;
                if (w_accept) w_next_state = w_is_div ? ST_DIV : ST_MUL;
            end
            ST_MUL, ST_DIV: begin
                if (r_count == c_LAST) w_next_state = ST_FIX;
            end
            ST_FIX:  w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
        Busy  = w_busy;
        Stall = Valid && w_busy && is_hilo_func(Func);
    end

    // ---------------- iteration datapath ----------------
    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .i_mode    (r_is_div ? STEP_DIV : STEP_MUL),
        .i_acc     (r_acc),
        .i_operand (r_operand),
        .o_acc     (w_acc_step)
    );

    // ---------------- sign correction ----------------
    always_comb begin
        w_prod = r_neg_res ? -r_acc : r_acc;
        if (!r_is_div) begin
            w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
            w_fix_lo = w_prod[WIDTH-1:0];
        end else if (r_div_zero) begin
            w_fix_hi = r_rs_raw;
            w_fix_lo = {WIDTH{1'b1}};
        end else begin
            w_fix_hi = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
            w_fix_lo = r_neg_res ? -r_acc[WIDTH-1:0]       : r_acc[WIDTH-1:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_count    <= '0;
            r_acc      <= '0;
            r_operand  <= '0;
            r_rs_raw   <= '0;
            r_is_div   <= 1'b0;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_div_zero <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= (r_state == ST_FIX);
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_acc      <= {{WIDTH{1'b0}}, w_rs_mag};
                        r_operand  <= w_rt_mag;
                        r_rs_raw   <= Rdata1;
                        r_is_div   <= w_is_div;
                        r_neg_res  <= w_rs_neg ^ w_rt_neg;
                        r_neg_rem  <= w_rs_neg;
                        r_div_zero <= w_is_div && (Rdata2 == '0);
                        r_count    <= '0;
                    end else if (Valid && (Func == FUNC_MTHI)) begin
                        r_hi <= Rdata1;
                    end else if (Valid && (Func == FUNC_MTLO)) begin
                        r_lo <= Rdata1;
                    end
                end
                ST_MUL, ST_DIV: begin
                    r_acc   <= w_acc_step;
                    r_count <= r_count + 1'b1;
                end
                ST_FIX: begin
                    r_hi <= w_fix_hi;
                    r_lo <= w_fix_lo;
                end
                default: ;
            endcase
        end
    end

    assign Done = r_done;
    assign HI   = r_hi;
    assign LO   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_ctrl
// Description : Self-checking bench for muldiv_ctrl: directed vector table,
//               hand-written multi-cycle sequences and randomized
//               back-to-back operations against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_ctrl;

    localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12,
                           F_MTLO = 6'h13, F_MULT = 6'h18, F_MULTU = 6'h19,
                           F_DIV  = 6'h1A, F_DIVU = 6'h1B, F_ADD  = 6'h20;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        Valid = 1'b0;
    logic [5:0]  Func = '0;
    logic [31:0] Rdata1 = '0, Rdata2 = '0;
    logic        Busy, Stall, Done;
    logic [31:0] HI, LO;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] m_hi = '0, m_lo = '0;

    muldiv_ctrl #(.WIDTH(32)) dut (
        .CLK(CLK), .RST(RST), .Valid(Valid), .Func(Func),
        .Rdata1(Rdata1), .Rdata2(Rdata2),
        .Busy(Busy), .Stall(Stall), .Done(Done), .HI(HI), .LO(LO)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    // Reference model computed directly from the arithmetic definition.
    task automatic ref_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] hi, output logic [31:0] lo);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        hi = '0; lo = '0;
        case (f)
            F_MULTU: begin p = {32'b0, a} * {32'b0, b}; hi = p[63:32]; lo = p[31:0]; end
            F_MULT:  begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
            F_DIVU:  if (b == 0) begin hi = a; lo = '1; end
                     else begin hi = a % b; lo = a / b; end
            F_DIV:   if (b == 0) begin hi = a; lo = '1; end
                     else begin
                         q = sa / sb; r = sa % sb;
                         hi = r[31:0]; lo = q[31:0];
                     end
            default: ;
        endcase
    endtask

    // Called at a negedge; presents the op, lets it be accepted and returns
    // at the negedge of the Done cycle (or after the cycle budget expires).
    task automatic run_op(input string name, input logic [5:0] f,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo);
        int k, busy_cnt;
        logic hilo_stable;
        Valid = 1'b1; Func = f; Rdata1 = a; Rdata2 = b;
        @(posedge CLK); #1;
        Valid = 1'b0; Func = F_ADD;
        k = 0; busy_cnt = 0; hilo_stable = 1'b1;
        do begin
            @(negedge CLK); k++;
            if (Busy) busy_cnt++;
            if (!Done && (HI !== m_hi || LO !== m_lo)) hilo_stable = 1'b0;
        end while (!Done && k < 60);
        check({name, " done_cycle"}, 32'(k), 32'd34);
        check({name, " busy_cycles"}, 32'(busy_cnt), 32'd33);
        check({name, " hilo_held_while_busy"}, 32'(hilo_stable), 32'd1);
        check({name, " HI"}, HI, ehi);
        check({name, " LO"}, LO, elo);
        m_hi = ehi; m_lo = elo;
    endtask

    typedef struct {
        logic [5:0]  f;
        logic [31:0] a, b, hi, lo;
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic [31:0] rhi, rlo;
        int k, stall_cnt;

        vecs[0] = '{F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1] = '{F_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[2] = '{F_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3] = '{F_DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
        vecs[4] = '{F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5] = '{F_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[6] = '{F_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};
        vecs[7] = '{F_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[8] = '{F_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};

        // ---- reset ----
        RST = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("reset Busy", 32'(Busy), 0);
        check("reset Done", 32'(Done), 0);
        check("reset Stall", 32'(Stall), 0);
        check("reset HI", HI, 0);
        check("reset LO", LO, 0);
        RST = 1'b1;
        @(negedge CLK);

        // ---- directed table, issued back-to-back ----
        for (int i = 0; i < 9; i++)
            run_op($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);

        // Done is a single pulse
        @(negedge CLK);
        check("done_pulse_width", 32'(Done), 0);
        check("idle_after_done Busy", 32'(Busy), 0);

        // ---- MTLO in IDLE ----
        Valid = 1'b1; Func = F_MTLO; Rdata1 = 32'h12345678;
        @(posedge CLK); #1; Valid = 1'b0; Func = F_ADD;
        @(negedge CLK);
        check("mtlo LO", LO, 32'h12345678);
        check("mtlo HI unchanged", HI, m_hi);
        check("mtlo Busy", 32'(Busy), 0);
        check("mtlo Done", 32'(Done), 0);
        m_lo = 32'h12345678;

        // ---- MFHI held from E1, ADD slipped in mid-operation ----
        Valid = 1'b1; Func = F_MULTU; Rdata1 = 32'hFFFFFFFF; Rdata2 = 32'hFFFFFFFF;
        @(posedge CLK); #1;
        Func = F_MFHI;
        k = 0; stall_cnt = 0;
        do begin
            @(negedge CLK); k++;
            if (Stall) stall_cnt++;
            if (k == 5) check("add_during_busy Stall", 32'(Stall), 0);
            Func = (k == 4) ? F_ADD : F_MFHI;
        end while (!Done && k < 60);
        check("mfhi done_cycle", 32'(k), 34);
        check("mfhi stall_cycles", 32'(stall_cnt), 32);
        check("mfhi done Stall", 32'(Stall), 0);
        check("mfhi done Busy", 32'(Busy), 0);
        check("mfhi done HI", HI, 32'hFFFFFFFE);
        m_hi = 32'hFFFFFFFE; m_lo = 32'h00000001;
        Valid = 1'b0; Func = F_ADD;
        @(negedge CLK);

        // ---- MTHI while busy: stalled, written only once IDLE ----
        Valid = 1'b1; Func = F_MULT; Rdata1 = 32'd2; Rdata2 = 32'd3;
        @(posedge CLK); #1;
        Func = F_MTHI; Rdata1 = 32'hDEADBEEF;
        k = 0; stall_cnt = 0;
        do begin
            @(negedge CLK); k++;
            if (Stall) stall_cnt++;
        end while (!Done && k < 60);
        check("mthi stall_cycles", 32'(stall_cnt), 33);
        check("mthi done HI (no early write)", HI, 32'h0);
        check("mthi done LO", LO, 32'h6);
        @(posedge CLK); #1; Valid = 1'b0; Func = F_ADD;
        @(negedge CLK);
        check("mthi after idle HI", HI, 32'hDEADBEEF);
        check("mthi after idle LO", LO, 32'h6);
        m_hi = 32'hDEADBEEF; m_lo = 32'h6;

        // ---- reset at E10 of a DIV ----
        Valid = 1'b1; Func = F_DIV; Rdata1 = 32'hFFFFFFF9; Rdata2 = 32'd2;
        @(posedge CLK); #1; Valid = 1'b0; Func = F_ADD;
        repeat (9) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        check("abort Busy", 32'(Busy), 0);
        check("abort HI", HI, 0);
        check("abort LO", LO, 0);
        check("abort Done", 32'(Done), 0);
        k = 0;
        repeat (40) begin @(negedge CLK); if (Done || Busy) k++; end
        check("abort no_done_or_busy", 32'(k), 0);
        m_hi = '0; m_lo = '0;
        run_op("post_abort_mult", F_MULT, 32'd2, 32'd3, 32'd0, 32'd6);

        // ---- randomized back-to-back operations ----
        for (int i = 0; i < 20; i++) begin
            logic [5:0]  f;
            logic [31:0] a, b;
            case ($urandom_range(3))
                0: f = F_MULT;  1: f = F_MULTU;
                2: f = F_DIV;   default: f = F_DIVU;
            endcase
            a = $urandom; b = $urandom;
            case ($urandom_range(7))
                0: b = 32'd0;
                1: a = 32'h80000000;
                2: b = 32'hFFFFFFFF;
                3: b = b >> $urandom_range(31);
                default: ;
            endcase
            ref_op(f, a, b, rhi, rlo);
            run_op($sformatf("rand%0d f=%02h a=%08h b=%08h", i, f, a, b), f, a, b, rhi, rlo);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
